// File: rtl/wb_uart_lite_pkg.sv
// Shared definitions for the Wishbone 8N1 UART: register offsets, STATUS bit
// positions, FSM state encodings and the divisor clamp.
package wb_uart_lite_pkg;

  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_CTRL   = 2'd2;
  localparam logic [1:0] UART_DIV    = 2'd3;

  localparam int ST_RX_VALID  = 0;
  localparam int ST_RX_FULL   = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_TX_EMPTY  = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_OVR    = 6;
  localparam int ST_WIDTH     = 7;

  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/wb_uart_lite_if.sv
// Wishbone B3 classic bus bundle between the interconnect (master) and the UART (slave).
interface wb_uart_lite_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_lite_fifo.sv
// Circular-buffer FIFO with an extra pointer bit for full/empty; a pop in the
// same cycle frees the slot a full-FIFO push needs.
module wb_uart_lite_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone classic slave UART (8N1) with TX/RX FIFOs, programmable baud divisor
// and a level interrupt.
module wb_uart_lite
  import wb_uart_lite_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_uart_lite_if.slave  wb,
  output logic           uart_txd_o,
  input  logic           uart_rxd_i,
  output logic           uart_int_o
);
  logic        req, wr_req, rd_req, status_rd;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic [15:0] div_wr;
  logic [ST_WIDTH-1:0] status;

  logic        ack_q, int_q;
  logic [31:0] dat_q;
  logic [1:0]  ctrl_q;
  logic [15:0] div_q;
  logic        rx_ovr_q, frame_err_q, tx_ovr_q;

  logic        tx_push, tx_pop, tx_full, tx_fifo_empty, tx_idle;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;

  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [7:0]  tx_shift_q;
  logic [2:0]  tx_bit_q;
  logic        txd_q;

  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [7:0]  rx_shift_q;
  logic [2:0]  rx_bit_q;
  logic [2:0]  rx_sync_q;
  logic        rx_line, rx_fall, rx_stop_smp;

  logic unused_bits;
  assign unused_bits = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_sel_i[3:2], wb.wb_dat_i[31:16]};

  assign req       = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign reg_sel   = wb.wb_adr_i[3:2];
  assign wr_req    = req & wb.wb_we_i;
  assign rd_req    = req & ~wb.wb_we_i;
  assign status_rd = rd_req & (reg_sel == UART_STATUS);
  assign div_wr    = {wb.wb_sel_i[1] ? wb.wb_dat_i[15:8] : div_q[15:8],
                      wb.wb_sel_i[0] ? wb.wb_dat_i[7:0]  : div_q[7:0]};

  assign tx_push = wr_req & (reg_sel == UART_DATA) & wb.wb_sel_i[0];
  assign rx_pop  = rd_req & (reg_sel == UART_DATA);
  // The FSM takes the next byte either from idle or on the last stop-bit cycle.
  assign tx_pop  = ~tx_fifo_empty & ((tx_state_q == TX_IDLE) |
                                     ((tx_state_q == TX_STOP) & (tx_cnt_q == 16'd0)));
  assign tx_idle = tx_fifo_empty & (tx_state_q == TX_IDLE);

  assign rx_line     = rx_sync_q[1];
  assign rx_fall     = rx_sync_q[2] & ~rx_sync_q[1];
  assign rx_stop_smp = (rx_state_q == RX_STOP) & (rx_cnt_q == 16'd0);
  assign rx_push     = rx_stop_smp & rx_line;

  always_comb begin
    status               = '0;
    status[ST_RX_VALID]  = ~rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_idle;
    status[ST_RX_OVR]    = rx_ovr_q;
    status[ST_FRAME_ERR] = frame_err_q;
    status[ST_TX_OVR]    = tx_ovr_q;
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      UART_DATA:   rd_data = {24'd0, rx_empty ? 8'd0 : rx_head};
      UART_STATUS: rd_data = {{(32-ST_WIDTH){1'b0}}, status};
      UART_CTRL:   rd_data = {30'd0, ctrl_q};
      default:     rd_data = {16'd0, div_q};
    endcase
  end

  wb_uart_lite_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(tx_push), .push_data_i(wb.wb_dat_i[7:0]),
    .pop_i(tx_pop), .head_o(tx_head), .full_o(tx_full), .empty_o(tx_fifo_empty)
  );

  wb_uart_lite_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(wb_clk_i), .rst_i(wb_rst_i), .push_i(rx_push), .push_data_i(rx_shift_q),
    .pop_i(rx_pop), .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  // Sticky flags: an event coinciding with the STATUS read keeps the flag set.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= 32'd0;
      ctrl_q      <= 2'd0;
      div_q       <= DIV_RESET;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tx_ovr_q    <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      ack_q <= req;
      if (req) dat_q <= rd_data;
      if (wr_req && reg_sel == UART_CTRL && wb.wb_sel_i[0]) ctrl_q <= wb.wb_dat_i[1:0];
      if (wr_req && reg_sel == UART_DIV && |wb.wb_sel_i[1:0]) div_q <= clamp_div(div_wr);
      tx_ovr_q    <= (tx_ovr_q & ~status_rd) | (tx_push & tx_full & ~tx_pop);
      rx_ovr_q    <= (rx_ovr_q & ~status_rd) | (rx_push & rx_full & ~rx_pop);
      frame_err_q <= (frame_err_q & ~status_rd) | (rx_stop_smp & ~rx_line);
      int_q       <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_idle);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_div_q   <= 16'd0;
      tx_shift_q <= 8'd0;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_div_q   <= div_q;
            tx_cnt_q   <= div_q - 16'd1;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == 16'd0) begin
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_cnt_q   <= tx_div_q - 16'd1;
            tx_bit_q   <= 3'd0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= tx_div_q - 16'd1;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              txd_q      <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt_q != 16'd0) begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end else if (tx_pop) begin
            tx_shift_q <= tx_head;
            tx_div_q   <= div_q;
            tx_cnt_q   <= div_q - 16'd1;
            txd_q      <= 1'b0;
            tx_state_q <= TX_START;
          end else begin
            tx_state_q <= TX_IDLE;
          end
        end
      endcase
    end
  end

  // rx_sync_q[1] is the synchronised line; rx_sync_q[2] is its previous value for edge detect.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_sync_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_div_q   <= 16'd0;
      rx_shift_q <= 8'd0;
      rx_bit_q   <= 3'd0;
    end else begin
      rx_sync_q <= {rx_sync_q[1:0], uart_rxd_i};
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_div_q   <= div_q;
            rx_cnt_q   <= (div_q >> 1) - 16'd1;
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else if (rx_line) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q   <= rx_div_q - 16'd1;
            rx_bit_q   <= 3'd0;
            rx_state_q <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == 16'd0) begin
            rx_shift_q <= {rx_line, rx_shift_q[7:1]};
            rx_cnt_q   <= rx_div_q - 16'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != 16'd0) rx_cnt_q   <= rx_cnt_q - 16'd1;
          else                   rx_state_q <= rx_line ? RX_IDLE : RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_line) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign uart_txd_o  = txd_q;
  assign uart_int_o  = int_q;
endmodule

// File: tb/tb_wb_uart_lite.sv
// Scoreboarded bench for wb_uart_lite: bus reads and serial frames are checked
// against queue-based models of the FIFOs and sticky flags.
`timescale 1ns/1ps
module tb_wb_uart_lite;
  logic clk = 1'b0;
  logic rst;
  logic txd, rxd, irq;
  logic loop_en, tb_rxd, dec_en;
  always #5 clk = ~clk;

  wb_uart_lite_if wb();
  assign rxd = loop_en ? txd : tb_rxd;

  wb_uart_lite #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb),
    .uart_txd_o(txd), .uart_rxd_i(rxd), .uart_int_o(irq)
  );

  int total = 0;
  int bad = 0;

  // Scoreboard of outstanding bus transactions.
  bit          sb_rd[$];
  logic [31:0] sb_exp[$];
  string       sb_nm[$];
  // Reference model.
  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_m[$];
  bit          m_rxovr, m_ferr, m_txovr;
  int          cur_div;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus(input bit we, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] sel, input logic [31:0] exp, input string nm);
    sb_rd.push_back(!we);
    sb_exp.push_back(exp);
    sb_nm.push_back(nm);
    @(posedge clk); #1;
    wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = {28'd0, a, 2'b00}; wb.wb_sel_i = sel; wb.wb_dat_i = d;
    @(posedge clk); #1;
    check({nm, "_ack"}, {63'd0, wb.wb_ack_o}, 64'd1);
    wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ackdrop"}, {63'd0, wb.wb_ack_o}, 64'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] sel);
    bus(1'b1, a, d, sel, 32'd0, "wr");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, a, 32'd0, 4'hF, exp, nm);
  endtask

  task automatic rd_status(input bit tx_full, input bit tx_empty, input string nm);
    logic [31:0] e;
    e = {25'd0, m_txovr, m_ferr, m_rxovr, tx_empty, tx_full,
         rx_m.size() == 8, rx_m.size() != 0};
    m_txovr = 0; m_ferr = 0; m_rxovr = 0;
    rd(2'd1, e, nm);
  endtask

  task automatic rd_data(input string nm);
    logic [31:0] e;
    e = (rx_m.size() != 0) ? {24'd0, rx_m.pop_front()} : 32'd0;
    rd(2'd0, e, nm);
  endtask

  task automatic set_div(input int v);
    wr(2'd3, v, 4'b0011);
    cur_div = (v < 4) ? 4 : v;
  endtask

  task automatic send(input logic [7:0] b);
    wr(2'd0, {24'd0, b}, 4'b0001);
    tx_exp.push_back(b);
    if (loop_en) begin
      if (rx_m.size() < 8) rx_m.push_back(b);
      else                 m_rxovr = 1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (tx_exp.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    check("drain_pending", tx_exp.size(), 64'd0);
    tx_exp.delete();
    repeat (2 * cur_div + 12) @(posedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] b, input bit stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      tb_rxd = f[i];
      repeat (cur_div) @(posedge clk);
      #1;
    end
    tb_rxd = 1'b1;
    repeat (3 * cur_div + 10) @(posedge clk);
  endtask

  // Bus monitor: every ack pops one scoreboard entry.
  always @(negedge clk) begin : bus_mon
    bit          r;
    logic [31:0] e;
    string       n;
    if (!rst && wb.wb_ack_o) begin
      if (sb_rd.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty: ack seen with dat_o=0x%08h, required no ack", wb.wb_dat_o);
      end else begin
        r = sb_rd.pop_front(); e = sb_exp.pop_front(); n = sb_nm.pop_front();
        if (r) check(n, {32'd0, wb.wb_dat_o}, {32'd0, e});
        $display("txn %s %s adr=%0d dat_o=0x%08h", r ? "rd" : "wr", n, wb.wb_adr_i[3:2], wb.wb_dat_o);
      end
    end
  end

  // Serial line monitor: decodes each TX frame at mid-bit.
  initial begin : tx_decoder
    logic [7:0] b;
    logic [7:0] e;
    logic       stopb;
    int         d;
    forever begin
      @(negedge clk);
      if (dec_en && !rst && txd === 1'b0) begin
        d = cur_div;
        repeat (d / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = txd;
        end
        repeat (d) @(negedge clk);
        stopb = txd;
        if (tx_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: frame 0x%02h seen, required none", b);
        end else begin
          e = tx_exp.pop_front();
          check("tx_frame", {55'd0, stopb, b}, {55'd0, 1'b1, e});
        end
        $display("frame tx=0x%02h stop=%0d", b, stopb);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [39:0] act_v, exp_v;
    logic [7:0]  p;
    int          n, k;
    bit          hi;
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
    wb.wb_adr_i = 0; wb.wb_sel_i = 0; wb.wb_dat_i = 0;
    loop_en = 0; tb_rxd = 1; dec_en = 1; cur_div = 434;
    m_rxovr = 0; m_ferr = 0; m_txovr = 0;
    rst = 1;
    repeat (4) @(posedge clk);
    #1 rst = 0;
    check("rst_txd", {63'd0, txd}, 64'd1);
    check("rst_int", {63'd0, irq}, 64'd0);
    check("rst_ack", {63'd0, wb.wb_ack_o}, 64'd0);
    check("rst_dat", {32'd0, wb.wb_dat_o}, 64'd0);
    rd_status(0, 1, "status_rst");
    rd(2'd3, 32'd434, "div_rst");
    rd(2'd2, 32'd0, "ctrl_rst");

    // Divisor lanes and clamp
    set_div(5);
    wr(2'd3, 32'h0000_0700, 4'b0010);
    rd(2'd3, 32'h0705, "div_lane1");
    set_div(2);
    rd(2'd3, 32'd4, "div_clamp");

    // Exact waveform of 0x55 at DIV=4
    send(8'h55);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin @(posedge clk); #1; n++; end
    p = 8'h55;
    for (int i = 0; i < 40; i++) begin
      exp_v[i] = (i < 4) ? 1'b0 : (i < 36) ? p[(i - 4) / 4] : 1'b1;
      act_v[i] = txd;
      @(posedge clk); #1;
    end
    check("txd_0x55", {24'd0, act_v}, {24'd0, exp_v});
    rd_status(0, 1, "status_after_55");
    wait_drain(200);

    // TX FIFO full / overrun while the FSM is busy
    set_div(40);
    send(8'h11);
    for (int i = 0; i < 8; i++) send(8'h20 + i[7:0]);
    rd_status(1, 0, "status_txfull");
    wr(2'd0, 32'h99, 4'b0001);
    m_txovr = 1;
    rd_status(1, 0, "status_txovr");
    rd_status(1, 0, "status_txovr_clr");
    wait_drain(9 * 10 * 40 + 400);
    rd_status(0, 1, "status_tx_drained");

    // Loopback single byte
    set_div(4);
    loop_en = 1;
    send(8'hA3);
    wait_drain(200);
    rd_status(0, 1, "status_rx_valid");
    rd_data("rx_a3");
    rd_data("rx_empty_read");
    rd_status(0, 1, "status_rx_drained");

    // Framing error, glitch, and a good hand-driven frame
    loop_en = 0;
    drive_frame(8'h5A, 1'b0);
    m_ferr = 1;
    rd_status(0, 1, "status_frame_err");
    @(posedge clk); #1 tb_rxd = 1'b0;
    @(posedge clk); #1 tb_rxd = 1'b1;
    repeat (20) @(posedge clk);
    rd_status(0, 1, "status_glitch");
    drive_frame(8'hC6, 1'b1);
    rx_m.push_back(8'hC6);
    rd_data("rx_c6");

    // RX overrun: nine looped bytes into an eight-entry FIFO
    loop_en = 1;
    for (int i = 0; i < 9; i++) send($urandom_range(0, 255));
    wait_drain(9 * 10 * 4 + 200);
    rd_status(0, 1, "status_rxovr");
    for (int i = 0; i < 9; i++) rd_data("rx_ovr_drain");

    // Randomised bursts at random divisors
    for (int it = 0; it < 12; it++) begin
      k = $urandom_range(1, 8);
      set_div($urandom_range(4, 9));
      for (int i = 0; i < k; i++) send($urandom_range(0, 255));
      wait_drain(k * 10 * cur_div + 200);
      rd_status(0, 1, "status_rand");
      for (int i = 0; i <= k; i++) rd_data("rx_rand");
    end

    // Interrupt
    set_div(4);
    wr(2'd2, 32'h1, 4'b0001);
    rd(2'd2, 32'h1, "ctrl_rd");
    check("int_idle", {63'd0, irq}, 64'd0);
    send(8'h3C);
    wait_drain(200);
    check("int_rx", {63'd0, irq}, 64'd1);
    rd_data("rx_int");
    check("int_clr", {63'd0, irq}, 64'd0);
    wr(2'd2, 32'h2, 4'b0001);
    @(posedge clk); #1;
    check("int_tx", {63'd0, irq}, 64'd1);
    wr(2'd2, 32'h0, 4'b0001);

    // Reset in the middle of a TX frame
    loop_en = 0; dec_en = 0;
    set_div(20);
    wr(2'd0, 32'h00, 4'b0001);
    wr(2'd0, 32'hFF, 4'b0001);
    wr(2'd0, 32'h12, 4'b0001);
    n = 0;
    while (txd !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
    repeat (30) @(posedge clk);
    #1;
    check("txd_before_rst", {63'd0, txd}, 64'd0);
    rst = 1;
    #1;
    check("txd_async_rst", {63'd0, txd}, 64'd1);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rx_m.delete(); m_rxovr = 0; m_ferr = 0; m_txovr = 0; cur_div = 434;
    rd_status(0, 1, "status_after_rst");
    rd(2'd3, 32'd434, "div_after_rst");
    hi = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      hi = hi & txd;
    end
    check("txd_idle_after_rst", {63'd0, hi}, 64'd1);
    check("sb_leftover", sb_rd.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
